// File: rtl/dcache_port_arbiter.sv
// Two-requester round-robin arbiter sharing one data-cache port.
// Latches the winning access and holds it on the cache until stall drops.
module dcache_port_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wd0,
    input  logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] rd0,
    output logic              stall0,
    input  logic              re1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] rd1,
    output logic              stall1,
    output logic              c_RE,
    output logic              c_WE,
    output logic [DATA_W-1:0] c_WD,
    output logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_RD,
    input  logic              c_stall,
    output logic              owner,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t             r_state;
    logic               r_rr_last;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_req0;
    logic               w_req1;
    logic               w_grant;
    logic               w_done;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_req0  = re0 | we0;
    assign w_req1  = re1 | we1;
    // On a tie the port that did not win last time goes first.
    assign w_grant = (w_req0 && w_req1) ? ~r_rr_last : w_req1;
    assign w_done  = (r_state == ST_OWN) && !c_stall;

    assign stall0 = w_req0 & ~(w_done & ~owner);
    assign stall1 = w_req1 & ~(w_done & owner);
    assign rd0    = owner ? '0 : c_RD;
    assign rd1    = owner ? c_RD : '0;

    assign w_cnt_inc = (r_stall_cnt == CNT_W'(TIMEOUT)) ? r_stall_cnt
                                                         : r_stall_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_last   <= 1'b1;
            r_stall_cnt <= '0;
            c_RE        <= 1'b0;
            c_WE        <= 1'b0;
            c_WD        <= '0;
            c_addr      <= '0;
            owner       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_state     <= ST_OWN;
                        owner       <= w_grant;
                        r_stall_cnt <= '0;
                        // A write takes precedence when both RE and WE are set.
                        if (w_grant) begin
                            c_WE   <= we1;
                            c_RE   <= ~we1;
                            c_addr <= addr1;
                            c_WD   <= wd1;
                        end else begin
                            c_WE   <= we0;
                            c_RE   <= ~we0;
                            c_addr <= addr0;
                            c_WD   <= wd0;
                        end
                    end
                end
                ST_OWN: begin
                    if (c_stall) begin
                        r_stall_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        r_rr_last <= owner;
                        c_RE      <= 1'b0;
                        c_WE      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dcache_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          re0, we0, re1, we1;
    logic [DW-1:0] wd0, wd1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] rd0, rd1;
    logic          stall0, stall1;
    logic          c_RE, c_WE;
    logic [DW-1:0] c_WD;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_RD;
    logic          c_stall;
    logic          owner, timeout_err;

    int n_tot = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    dcache_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .re0(re0), .we0(we0), .wd0(wd0), .addr0(addr0), .rd0(rd0), .stall0(stall0),
        .re1(re1), .we1(we1), .wd1(wd1), .addr1(addr1), .rd1(rd1), .stall1(stall1),
        .c_RE(c_RE), .c_WE(c_WE), .c_WD(c_WD), .c_addr(c_addr),
        .c_RD(c_RD), .c_stall(c_stall), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Tiny cache: 16 words indexed by the low address bits.
    logic [DW-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    assign c_RD = mem[c_addr[3:0]];
    always @(posedge clk) if (reset && c_WE && !c_stall) mem[c_addr[3:0]] <= c_WD;

    // Transaction model: one outstanding access, who owns it, and fairness history.
    bit          m_busy, m_port, m_wr, m_last, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    int          m_stalls;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy = 0; m_port = 0; m_wr = 0; m_last = 1; m_err = 0;
            m_addr = '0; m_wd = '0; m_stalls = 0;
        end else if (!m_busy) begin
            if (re0 | we0 | re1 | we1) begin
                if ((re0 | we0) && (re1 | we1)) m_port = !m_last;
                else                            m_port = (re1 | we1);
                m_busy   = 1;
                m_stalls = 0;
                m_wr   = m_port ? we1 : we0;
                m_addr = m_port ? addr1 : addr0;
                m_wd   = m_port ? wd1 : wd0;
            end
        end else if (c_stall) begin
            m_stalls++;
            if (m_stalls >= TO) m_err = 1;
        end else begin
            m_busy = 0;
            m_last = m_port;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("m.c_RE",   32'(c_RE),  32'(m_busy && !m_wr));
            chk("m.c_WE",   32'(c_WE),  32'(m_busy && m_wr));
            chk("m.c_addr", c_addr,     m_addr);
            chk("m.c_WD",   c_WD,       m_wd);
            chk("m.owner",  32'(owner), 32'(m_port));
            chk("m.terr",   32'(timeout_err), 32'(m_err));
            chk("m.stall0", 32'(stall0), 32'((re0 | we0) && !(m_busy && m_port == 0 && !c_stall)));
            chk("m.stall1", 32'(stall1), 32'((re1 | we1) && !(m_busy && m_port == 1 && !c_stall)));
            chk("m.rd0",    rd0, (m_port == 0) ? c_RD : 32'h0);
            chk("m.rd1",    rd1, (m_port == 1) ? c_RD : 32'h0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        re0 = 0; we0 = 0; wd0 = '0; addr0 = '0;
        re1 = 0; we1 = 0; wd1 = '0; addr1 = '0;
        c_stall = 0;
    endtask

    task automatic rst();
        reset = 0;
        clear_in();
        cyc(2);
        reset = 1;
    endtask

    initial begin
        clear_in();
        // Reset held with a pending read on port 0.
        reset = 0; re0 = 1;
        cyc(1);
        check_en = 1;
        cyc(3);
        @(negedge clk);
        chk("rst.c_RE", 32'(c_RE), 32'h0);
        chk("rst.stall0", 32'(stall0), 32'h1);
        chk("rst.terr", 32'(timeout_err), 32'h0);
        reset = 1;
        cyc(1);
        @(negedge clk);
        chk("rel.c_RE", 32'(c_RE), 32'h1);
        chk("rel.c_addr", c_addr, 32'h0);
        chk("rel.stall0", 32'(stall0), 32'h0);
        re0 = 0;
        cyc(1);

        // Write 100 to address 0, then read it back on port 0.
        @(negedge clk);
        we0 = 1; wd0 = 32'd100; addr0 = '0;
        cyc(1);
        @(negedge clk);
        chk("wr.c_WE", 32'(c_WE), 32'h1);
        chk("wr.c_WD", c_WD, 32'd100);
        chk("wr.stall0", 32'(stall0), 32'h0);
        we0 = 0; re0 = 1;
        cyc(2);
        @(negedge clk);
        chk("rdback.c_RE", 32'(c_RE), 32'h1);
        chk("rdback.rd0", rd0, 32'd100);
        re0 = 0;
        cyc(2);

        // Tie after reset: port 0 first, long cache stall, then port 1, then port 0.
        rst();
        re0 = 1; addr0 = 32'h001DA009;
        re1 = 1; addr1 = 32'h0133003F;
        c_stall = 1;
        cyc(1);
        @(negedge clk);
        chk("tie.owner0", 32'(owner), 32'h0);
        chk("tie.addr0", c_addr, 32'h001DA009);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("tie.stall1", 32'(stall1), 32'h1);
            cyc(1);
        end
        c_stall = 0;
        @(negedge clk);
        chk("tie.done0", 32'(stall0), 32'h0);
        cyc(2);
        @(negedge clk);
        chk("tie.owner1", 32'(owner), 32'h1);
        chk("tie.addr1", c_addr, 32'h0133003F);
        cyc(2);
        @(negedge clk);
        chk("tie.owner0b", 32'(owner), 32'h0);
        re0 = 0; re1 = 0;
        cyc(2);

        // Port 1 drops its request mid-access; latched access still completes.
        rst();
        re1 = 1; addr1 = 32'h55; c_stall = 1;
        cyc(1);
        @(negedge clk);
        re1 = 0; addr1 = 32'h99;
        cyc(3);
        @(negedge clk);
        chk("drop.c_RE", 32'(c_RE), 32'h1);
        chk("drop.c_addr", c_addr, 32'h55);
        chk("drop.stall1", 32'(stall1), 32'h0);
        c_stall = 0; re0 = 1; re1 = 1; addr0 = 32'h7;
        cyc(2);
        @(negedge clk);
        chk("drop.owner0", 32'(owner), 32'h0);
        re0 = 0; re1 = 0;
        cyc(2);

        // Timeout: 20 stall cycles against a limit of 16.
        rst();
        re0 = 1; addr0 = 32'h10; c_stall = 1;
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("to.early", 32'(timeout_err), 32'h0);
            cyc(1);
        end
        @(negedge clk);
        chk("to.set", 32'(timeout_err), 32'h1);
        cyc(4);
        c_stall = 0; re0 = 0;
        cyc(4);
        @(negedge clk);
        chk("to.sticky", 32'(timeout_err), 32'h1);
        rst();
        @(negedge clk);
        chk("to.clear", 32'(timeout_err), 32'h0);

        // Read and write together: write wins.
        re0 = 1; we0 = 1; wd0 = 32'd200; addr0 = 32'h0141B033;
        cyc(1);
        @(negedge clk);
        chk("rw.c_WE", 32'(c_WE), 32'h1);
        chk("rw.c_RE", 32'(c_RE), 32'h0);
        chk("rw.c_WD", c_WD, 32'd200);
        re0 = 0; we0 = 0;
        cyc(3);

        check_en = 0;
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
